// File: rtl/cnn1d_pkg.sv
// Shared types and helpers for the 1D CNN pipeline stages.
// Holds the pooling mode/state enums and the constant clog2 helper.
package cnn1d_pkg;

    typedef enum logic {POOL_AVG = 1'b0, POOL_MAX = 1'b1} pool_mode_t;
    typedef enum logic {GP_ACCUM, GP_DRAIN} gpool_state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gpool_lane.sv
// One channel's pooling accumulator: running sum (avg) or running max.
// A load with i_first set restarts the accumulator from the new sample.
module gpool_lane
    import cnn1d_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ACC_W      = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_load,
    input  logic                         i_first,
    input  pool_mode_t                   i_mode,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    output logic signed [ACC_W-1:0]      o_acc
);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_ext;

    assign w_ext = ACC_W'(i_data);
    assign o_acc = r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_load) begin
            if (i_first) begin
                r_acc <= w_ext;
            end else if (i_mode == POOL_MAX) begin
                r_acc <= (w_ext > r_acc) ? w_ext : r_acc;
            end else begin
                r_acc <= r_acc + w_ext;
            end
        end
    end

endmodule

// File: rtl/gpool_mc.sv
// Multi-channel global pooling stage (avg/max per frame, interleaved input).
// Define GPOOL_ROUND_EN for round-half-up averaging instead of floor.
module gpool_mc
    import cnn1d_pkg::*;
#(
    parameter int DATA_WIDTH   = 12,
    parameter int POOL_SIZE    = 256,
    parameter int NUM_CHANNELS = 4,
    parameter int CHAN_WIDTH   = (clog2(NUM_CHANNELS) < 1) ? 1 : clog2(NUM_CHANNELS)
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         gpool_ready_in,
    input  logic                         gpool_valid_in,
    input  logic signed [DATA_WIDTH-1:0] gpool_data_in,
    input  logic                         gpool_mode,
    input  logic                         gpool_ready_out,
    output logic                         gpool_valid_out,
    output logic signed [DATA_WIDTH-1:0] gpool_data_out,
    output logic [CHAN_WIDTH-1:0]        gpool_chan_out,
    output logic                         gpool_last_out
);

    localparam int SHIFT  = clog2(POOL_SIZE);
    localparam int ACC_W  = DATA_WIDTH + SHIFT;
    localparam int SAMP_W = (SHIFT < 1) ? 1 : SHIFT;
    localparam int RND    = (1 << SHIFT) >> 1;

    gpool_state_t            r_state;
    gpool_state_t            w_state_nxt;
    pool_mode_t              r_mode;
    pool_mode_t              w_mode;
    logic [CHAN_WIDTH-1:0]   r_chan_cnt;
    logic [SAMP_W-1:0]       r_samp_cnt;
    logic [CHAN_WIDTH-1:0]   r_drain_idx;

    logic                    w_accept;
    logic                    w_chan_wrap;
    logic                    w_samp_last;
    logic                    w_first;
    logic                    w_frame_end;
    logic                    w_hs;
    logic                    w_drain_last;
    logic [NUM_CHANNELS-1:0] w_load;
    logic signed [ACC_W-1:0] w_acc [NUM_CHANNELS];
    logic signed [ACC_W-1:0] w_sel;
    logic signed [DATA_WIDTH-1:0] w_avg;

    assign w_accept     = gpool_valid_in && (r_state == GP_ACCUM);
    assign w_chan_wrap  = (r_chan_cnt == CHAN_WIDTH'(NUM_CHANNELS - 1));
    assign w_samp_last  = (r_samp_cnt == SAMP_W'(POOL_SIZE - 1));
    assign w_first      = (r_samp_cnt == '0);
    assign w_frame_end  = w_accept && w_chan_wrap && w_samp_last;
    assign w_hs         = (r_state == GP_DRAIN) && gpool_ready_out;
    assign w_drain_last = (r_drain_idx == CHAN_WIDTH'(NUM_CHANNELS - 1));

    // The frame's mode comes straight from the port on its very first beat.
    assign w_mode = (w_first && r_chan_cnt == '0) ? pool_mode_t'(gpool_mode) : r_mode;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
        assign w_load[g] = w_accept && (r_chan_cnt == CHAN_WIDTH'(g));

        gpool_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_W      (ACC_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[g]),
            .i_first (w_first),
            .i_mode  (w_mode),
            .i_data  (gpool_data_in),
            .o_acc   (w_acc[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= GP_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= POOL_AVG;
        end else if (w_accept && w_first && r_chan_cnt == '0) begin
            r_mode <= pool_mode_t'(gpool_mode);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chan_cnt  <= '0;
            r_samp_cnt  <= '0;
            r_drain_idx <= '0;
        end else if (r_state == GP_ACCUM) begin
            if (w_accept) begin
                r_chan_cnt <= w_chan_wrap ? '0 : r_chan_cnt + 1'b1;
                if (w_chan_wrap) begin
                    r_samp_cnt <= w_samp_last ? '0 : r_samp_cnt + 1'b1;
                end
            end
        end else if (w_hs) begin
            r_drain_idx <= w_drain_last ? '0 : r_drain_idx + 1'b1;
            r_chan_cnt  <= '0;
            r_samp_cnt  <= '0;
        end
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (r_drain_idx == CHAN_WIDTH'(i)) begin
                w_sel = w_acc[i];
            end
        end
    end

`ifdef GPOOL_ROUND_EN
    // One guard bit keeps the half-LSB add from overflowing the accumulator.
    logic signed [ACC_W:0] w_rnd;
    assign w_rnd = (ACC_W + 1)'(w_sel) + (ACC_W + 1)'(RND);
    assign w_avg = DATA_WIDTH'(w_rnd >>> SHIFT);
`else
    assign w_avg = DATA_WIDTH'(w_sel >>> SHIFT);
`endif

    always_comb begin
        w_state_nxt     = r_state;
        gpool_ready_in  = 1'b0;
        gpool_valid_out = 1'b0;
        gpool_data_out  = '0;
        gpool_chan_out  = '0;
        gpool_last_out  = 1'b0;
        unique case (r_state)
            GP_ACCUM: begin
                gpool_ready_in = 1'b1;
                if (w_frame_end) begin
                    w_state_nxt = GP_DRAIN;
                end
            end
            GP_DRAIN: begin
                gpool_valid_out = 1'b1;
                gpool_chan_out  = r_drain_idx;
                gpool_last_out  = w_drain_last;
                gpool_data_out  = (r_mode == POOL_MAX) ? DATA_WIDTH'(w_sel) : w_avg;
                if (w_hs && w_drain_last) begin
                    w_state_nxt = GP_ACCUM;
                end
            end
            default: w_state_nxt = GP_ACCUM;
        endcase
    end

endmodule

// File: doc/gpool_mc.md
Name: gpool_mc

Overview:
- Multi-channel global pooling stage with average or max mode, selected per frame.
- Consumes a channel-interleaved AXI-style stream: per time step ch0..chN-1, POOL_SIZE time steps per frame.
- Emits one pooled result per channel, in channel order, tagged with a channel index and a last flag.
- Sits between the final conv stage and the dense/classifier stage of the 1D CNN.

Parameters:
- DATA_WIDTH, 12: signed two's-complement sample width, in and out.
- POOL_SIZE, 256: time steps per channel per frame. Need not be a power of two.
- NUM_CHANNELS, 4: interleaved channels.
- CHAN_WIDTH, max(1, clog2(NUM_CHANNELS)): width of the channel index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- gpool_ready_in  out  1  block can accept an input sample.
- gpool_valid_in  in  1  input sample valid.
- gpool_data_in  in  DATA_WIDTH  signed input sample.
- gpool_mode  in  1  0 = average, 1 = max; sampled on the first accepted beat of a frame.
- gpool_ready_out  in  1  downstream ready.
- gpool_valid_out  out  1  output result valid.
- gpool_data_out  out  DATA_WIDTH  pooled result.
- gpool_chan_out  out  CHAN_WIDTH  channel of the current result.
- gpool_last_out  out  1  high with the result for channel NUM_CHANNELS-1.

Behaviour:
- Reset values:
  - all outputs 0 except gpool_ready_in = 1;
  - state ACCUM, counters 0, accumulators 0, mode register 0.
- Reset mid-frame or mid-drain discards everything. The next accepted beat is ch0, t0.
- State ACCUM:
  - gpool_ready_in = 1; a beat is accepted when valid_in && ready_in.
  - chan_cnt increments per accepted beat and wraps at NUM_CHANNELS-1. samp_cnt increments on each chan_cnt wrap.
  - On the first beat of a frame (samp_cnt = 0, chan_cnt = 0), gpool_mode is latched. It is ignored for the rest of the frame.
  - Accumulator width ACC_W = DATA_WIDTH + clog2(POOL_SIZE), signed, one per channel.
  - Avg mode: acc[ch] = (samp_cnt == 0) ? sext(data) : acc[ch] + sext(data).
  - Max mode: acc[ch] = (samp_cnt == 0) ? sext(data) : max_signed(acc[ch], sext(data)).
  - The accept of beat (ch = NUM_CHANNELS-1, t = POOL_SIZE-1) moves to DRAIN.
- State DRAIN:
  - gpool_ready_in = 0.
  - Output index drain_idx runs 0..NUM_CHANNELS-1. The result presents with gpool_valid_out = 1 the cycle after entry, so latency is 1 cycle from the last accept.
  - Avg result: (acc >>> clog2(POOL_SIZE))[DATA_WIDTH-1:0]. This is an arithmetic shift; for a non-power-of-2 POOL_SIZE the result is a scaled mean by design.
  - Max result: acc[DATA_WIDTH-1:0].
  - drain_idx advances on each valid_out && ready_out.
  - gpool_last_out = (drain_idx == NUM_CHANNELS-1).
  - The last handshake returns to ACCUM. gpool_ready_in = 1 in the following cycle, and counters are zeroed.
- Backpressure: while valid_out && !ready_out, data_out, chan_out and last_out hold stable. No result is ever dropped or duplicated.
- NUM_CHANNELS = 1 and POOL_SIZE = 1 are legal. With POOL_SIZE = 1, avg shift = 0 and output = input.

Optional Feature:
- Macro GPOOL_ROUND_EN.
- Defined: avg mode adds 2^(clog2(POOL_SIZE)-1) before the shift, i.e. round-half-up. No rounding add when POOL_SIZE = 1. The adder is sized so the add cannot overflow ACC_W. Max mode is unaffected.
- Undefined: truncating arithmetic shift (floor).

Decomposition:
- cnn1d_pkg gains:
  - typedef enum logic {POOL_AVG = 1'b0, POOL_MAX = 1'b1} pool_mode_t;
  - typedef enum logic {GP_ACCUM, GP_DRAIN} gpool_state_t;
  - reuse of the existing clog2 function.
- Sub-module gpool_lane: one channel's accumulator, with inputs load/first, mode, data and output acc. Instantiated NUM_CHANNELS times by a generate loop.
- Counters, FSM and output mux stay in gpool_mc.

Test Plan (DATA_WIDTH = 12, POOL_SIZE = 4, NUM_CHANNELS = 2 unless noted):
- Avg, macro off: ch0 = 4,8,12,16; ch1 = -1,-1,-1,-1 → out (10, chan 0, last 0), then (-1, chan 1, last 1). valid_out rises 1 cycle after the 8th accept.
- Max: ch0 = -5,3,-2,7; ch1 = -8,-3,-6,-9 → 7, then -3. All-negative input must not yield 0.
- GPOOL_ROUND_EN defined vs undefined, avg: ch0 = 1,2,1,2 (sum 6) → 2 with the macro, 1 without.
- Backpressure: ready_out low for 5 cycles during DRAIN → data, chan and last stable. ready_in = 0 throughout; input valid pulses ignored. Exactly 2 results delivered.
- Mode latch: gpool_mode = 1 on the first beat, toggled to 0 mid-frame → max results. Back-to-back frames with modes 0 then 1 each pool correctly, and counters restart at ch0.
- Reset mid-frame after 3 beats, then a clean frame of ch0 = 4 × 100, ch1 = 4 × 200 → avg outputs 100, 200 with no residue from the aborted frame.
